// File: rtl/puf_ref_serializer_if.sv
// ----------------------------------------------------------------------------
// puf_ref_serializer_if
//   Byte-wide valid/ready stream carrying the serialized reference word out to
//   a UART TX or host link.
//   tx_data  : current byte, MSB-first order within the word
//   tx_valid : tx_data is valid; once raised it stays up until accepted
//   tx_ready : sink accepts the byte when tx_valid & tx_ready at a rising edge
//   tx_last  : asserted with tx_valid on the final byte of the word
//   modport master : the serializer (drives data/valid/last)
//   modport slave  : the byte sink (drives ready)
// ----------------------------------------------------------------------------
interface puf_ref_serializer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/puf_ref_serializer.sv
// ----------------------------------------------------------------------------
// puf_ref_serializer
//   Reads one word from the challenge->reference ROM and streams it out
//   MSB-first as DATA_SZ/8 bytes over a valid/ready byte interface, then
//   pulses done for one cycle.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : transaction request, honoured only while idle
//   addr_in  : challenge / ROM address, captured with start
//   busy     : high whenever a transaction is in progress
//   rom_addr : registered ROM address, stable for the whole transaction
//   rom_data : combinational ROM word, captured one cycle after start
//   tx       : byte stream (master side)
//   done     : one-cycle pulse after the last byte has been accepted
// ----------------------------------------------------------------------------
module puf_ref_serializer #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 264    // must be a multiple of 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_SZ-1:0]      addr_in,
  output logic                    busy,
  output logic [ADDR_SZ-1:0]      rom_addr,
  input  logic [DATA_SZ-1:0]      rom_data,
  puf_ref_serializer_if.master    tx,
  output logic                    done
);

  localparam int NBYTES = DATA_SZ / 8;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,   // ROM address has been registered; ROM output settles here
    ST_SEND,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SZ-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_SZ-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values computed by the comb blocks.
  // The shift register is reset too: a reset mid-transfer must discard the
  // partial word so tx_data returns to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      shreg_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default before the case statement,
  // so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    shreg_d    = shreg_q;
    count_d    = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // start is looked at only here, so requests while busy are dropped.
        if (start) begin
          rom_addr_d = addr_in;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        shreg_d = rom_data;
        count_d = '0;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        // Without a handshake nothing moves, so tx_data/tx_last stay stable.
        if (tx.tx_ready) begin
          shreg_d = shreg_q << 8;
          if (count_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so tx_ready never reaches an
  // output combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    rom_addr    = rom_addr_q;
    tx.tx_valid = (state_q == ST_SEND);
    tx.tx_last  = (state_q == ST_SEND) && (count_q == LAST_IDX);
    tx.tx_data  = shreg_q[DATA_SZ-1 -: 8];
  end

endmodule
